// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if
// Groups the start/operand/result handshake between the multdiv front end,
// the div_ctrl sequencer and the restoring divider datapath.
//   slave  modport : used by div_ctrl (drives the divider side and results)
//   master modport : used by whoever issues divides and supplies div_result
// Signals:
//   ctrl_DIV          start request pulse
//   data_operandA/B   dividend / divisor sampled with ctrl_DIV
//   div_result        combinational quotient from the divider datapath
//   div_operandA/B    latched operands held for the divider
//   div_ctrl          divider accumulator clear (high while idle)
//   div_counter_zero  divider load strobe
//   data_result       registered quotient
//   data_exception    registered divide-by-zero flag
//   data_resultRDY    one-cycle completion pulse
//   busy              operation in progress
// ---------------------------------------------------------------------------
interface div_ctrl_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] div_result;
  logic [31:0] div_operandA;
  logic [31:0] div_operandB;
  logic        div_ctrl;
  logic        div_counter_zero;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB, div_result,
    output div_operandA, div_operandB, div_ctrl, div_counter_zero,
           data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_DIV, data_operandA, data_operandB, div_result,
    input  div_operandA, div_operandB, div_ctrl, div_counter_zero,
           data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Sequencer for the restoring divider in the multdiv unit. Latches operands
// on a start request, strobes the divider clear/load, counts ITERATIONS
// iterations, then registers the quotient with a one-cycle ready pulse and a
// divide-by-zero flag.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      div_ctrl_if.slave (start/operands in, divider strobes and
//            registered results out)
// Configuration:
//   DIV_CTRL_ZERO_SHORTCUT_EN  when defined, a start with a zero divisor skips
//   the divider entirely and completes one edge after the start.
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int ITERATIONS = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, CAPT} state_t;

  localparam logic [5:0] LastCount = 6'(ITERATIONS - 1);

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        zeroDivisor;
  logic        startZeroDivisor;

  assign zeroDivisor      = (opB_q == 32'd0);
  assign startZeroDivisor = (bus.data_operandB == 32'd0);

  // Next-state logic. A start request wins over everything, which is what
  // makes a start during LOAD/ITER/CAPT an abort: the CAPT branch that would
  // have produced the RDY pulse is simply never taken.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (bus.ctrl_DIV) begin
      opA_d   = bus.data_operandA;
      opB_d   = bus.data_operandB;
      count_d = 6'd0;
`ifdef DIV_CTRL_ZERO_SHORTCUT_EN
      state_d = startZeroDivisor ? CAPT : LOAD;
`else
      state_d = LOAD;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: state_d = ITER;
        ITER: begin
          count_d = count_q + 6'd1;
          if (count_q == LastCount) state_d = CAPT;
        end
        CAPT: begin
          // Zero divisor forces the quotient to 0 whatever the datapath holds.
          result_d = zeroDivisor ? 32'd0 : bus.div_result;
          exc_d    = zeroDivisor;
          rdy_d    = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers; reset puts the controller idle with the
  // divider held in clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= 6'd0;
      opA_q    <= 32'd0;
      opB_q    <= 32'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Divider strobes and busy are pure decodes of the state register.
  assign bus.div_ctrl         = (state_q == IDLE);
  assign bus.div_counter_zero = (state_q == LOAD);
  assign bus.busy             = (state_q != IDLE);
  assign bus.div_operandA     = opA_q;
  assign bus.div_operandB     = opB_q;
  assign bus.data_result      = result_q;
  assign bus.data_exception   = exc_q;
  assign bus.data_resultRDY   = rdy_q;

`ifndef DIV_CTRL_ZERO_SHORTCUT_EN
  // Only consumed by the zero-divisor shortcut build.
  logic unusedStartZero;
  assign unusedStartZero = startZeroDivisor;
`endif

endmodule
